// File: rtl/gcd_pkg.sv
// ============================================================================
// gcd_pkg -- shared FSM encoding, default sizes and index-width helper
// Rev 1.0
// ============================================================================
`default_nettype none

package gcd_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int TIMEOUT_DEF = 1023;
  localparam int CNT_W       = 16;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LAUNCH  = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_DELIVER = 2'd3;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gcd_arbiter_if.sv
// ============================================================================
// gcd_arbiter_if -- requester bus and shared-core link of the GCD arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

interface gcd_arbiter_if import gcd_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int WIDTH = WIDTH_DEF
);

  logic [N_REQ-1:0]       req_i;
  logic [N_REQ*WIDTH-1:0] zahl1_i;
  logic [N_REQ*WIDTH-1:0] zahl2_i;
  logic [N_REQ-1:0]       ack_o;
  logic [N_REQ-1:0]       done_o;
  logic [WIDTH-1:0]       erg_o;
  logic                   err_o;
  logic                   busy_o;
  logic                   core_start_o;
  logic [WIDTH-1:0]       core_zahl1_o;
  logic [WIDTH-1:0]       core_zahl2_o;
  logic                   core_valid_i;
  logic [WIDTH-1:0]       core_erg_i;

  modport slave (
    input  req_i, zahl1_i, zahl2_i, core_valid_i, core_erg_i,
    output ack_o, done_o, erg_o, err_o, busy_o,
           core_start_o, core_zahl1_o, core_zahl2_o
  );

  modport master (
    output req_i, zahl1_i, zahl2_i, core_valid_i, core_erg_i,
    input  ack_o, done_o, erg_o, err_o, busy_o,
           core_start_o, core_zahl1_o, core_zahl2_o
  );

endinterface

`default_nettype wire

// File: rtl/gcd_arbiter_rr_select.sv
// ============================================================================
// rr_select -- round-robin pick of the first request at or above the pointer
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_select import gcd_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  localparam logic [IDX_W:0] c_n = (IDX_W+1)'(N_REQ);

  logic [N_REQ-1:0] w_rot;
  logic [IDX_W-1:0] w_off;
  logic [IDX_W:0]   w_sum;

  always_comb begin
    // Rotate so the pointer position lands at bit 0; lowest set bit wins.
    w_rot = N_REQ'({req_i, req_i} >> ptr_i);
    w_off = '0;
    any_o = 1'b0;
    for (int p = N_REQ - 1; p >= 0; p--) begin
      if (w_rot[p]) begin
        w_off = IDX_W'(p);
        any_o = 1'b1;
      end
    end
    w_sum = {1'b0, ptr_i} + {1'b0, w_off};
    idx_o = (w_sum >= c_n) ? IDX_W'(w_sum - c_n) : IDX_W'(w_sum);
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_grant
    assign grant_o[g] = any_o && (idx_o == IDX_W'(g));
  end

endmodule

`default_nettype wire

// File: rtl/gcd_arbiter.sv
// ============================================================================
// gcd_arbiter -- round-robin front end sharing one GCD core among requesters
// Rev 1.0
// ============================================================================
`default_nettype none

module gcd_arbiter import gcd_pkg::*; #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         rst_n_i,
  gcd_arbiter_if.slave bus
);

  localparam int              IDX_W      = idx_width(N_REQ);
  localparam logic [CNT_W-1:0] c_to_last = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(N_REQ - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0]   op1_q, op1_d;
  logic [WIDTH-1:0]   op2_q, op2_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               res_err_q, res_err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [WIDTH-1:0]   erg_q, erg_d;
  logic               err_q, err_d;

  logic [N_REQ-1:0]   w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic [WIDTH-1:0]   w_op1;
  logic [WIDTH-1:0]   w_op2;
  logic [N_REQ-1:0]   w_idx_oh;
  logic               w_bypass;

  rr_select #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .req_i   (bus.req_i),
    .ptr_i   (ptr_q),
    .grant_o (w_grant),
    .idx_o   (w_idx),
    .any_o   (w_any)
  );

  always_comb begin
    w_op1 = '0;
    w_op2 = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_grant[k]) begin
        w_op1 = bus.zahl1_i[k*WIDTH +: WIDTH];
        w_op2 = bus.zahl2_i[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_idx_oh = N_REQ'(1) << idx_q;
  assign w_bypass = (op1_q == '0) || (op2_q == '0);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    res_d     = res_q;
    res_err_d = res_err_q;
    cnt_d     = cnt_q;
    done_d    = '0;
    erg_d     = erg_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (w_any) begin
          idx_d   = w_idx;
          op1_d   = w_op1;
          op2_d   = w_op2;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        cnt_d = '0;
        if (w_bypass) begin
          // With one operand zero the OR is the other operand, and 0 for gcd(0,0).
          res_d     = op1_q | op2_q;
          res_err_d = 1'b0;
          state_d   = ST_DELIVER;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.core_valid_i) begin
          res_d     = bus.core_erg_i;
          res_err_d = 1'b0;
          state_d   = ST_DELIVER;
        end else if (cnt_q == c_to_last) begin
          res_d     = '0;
          res_err_d = 1'b1;
          state_d   = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        done_d  = w_idx_oh;
        erg_d   = res_q;
        err_d   = res_err_q;
        ptr_d   = (idx_q == c_idx_last) ? '0 : idx_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      ptr_q     <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      res_q     <= '0;
      res_err_q <= 1'b0;
      cnt_q     <= '0;
      done_q    <= '0;
      erg_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      res_q     <= res_d;
      res_err_q <= res_err_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      erg_q     <= erg_d;
      err_q     <= err_d;
    end
  end

  assign bus.ack_o        = (state_q == ST_LAUNCH) ? w_idx_oh : '0;
  assign bus.core_start_o = (state_q == ST_LAUNCH) && !w_bypass;
  assign bus.core_zahl1_o = ((state_q == ST_LAUNCH) || (state_q == ST_WAIT)) ? op1_q : '0;
  assign bus.core_zahl2_o = ((state_q == ST_LAUNCH) || (state_q == ST_WAIT)) ? op2_q : '0;
  assign bus.done_o       = done_q;
  assign bus.erg_o        = erg_q;
  assign bus.err_o        = err_q;
  assign bus.busy_o       = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_gcd_arbiter.sv
// ============================================================================
// tb_gcd_arbiter -- self-checking bench with vector table and random traffic
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_gcd_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gcd_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  gcd_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;
  int ref_ptr  = 0;
  logic [W-1:0] last_erg;
  logic         last_err;

  typedef struct {
    logic [N-1:0] mask;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           lat;
    logic [W-1:0] cerg;
    int           idx;
    logic [W-1:0] erg;
    logic         err;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_pick(input logic [N-1:0] m, input int ptr);
    for (int o = 0; o < N; o++) begin
      if (m[(ptr + o) % N]) return (ptr + o) % N;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    int x, y, t;
    x = int'(a);
    y = int'(b);
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return W'(x);
  endfunction

  // One full request: drive, expect ack next cycle, play the core, expect done.
  task automatic do_txn(input logic [N-1:0] mask, input logic [N*W-1:0] z1,
                        input logic [N*W-1:0] z2, input int lat, input logic [W-1:0] cerg,
                        input bit hold, input int exp_idx, input logic [W-1:0] exp_erg,
                        input logic exp_err);
    logic [W-1:0] a, b;
    bit byp, seen;
    int exp_lat, starts;
    a = z1[exp_idx*W +: W];
    b = z2[exp_idx*W +: W];
    byp = (a == 0) || (b == 0);
    exp_lat = byp ? 2 : ((lat >= 1 && lat <= TO) ? lat + 2 : TO + 2);
    bus.req_i = mask;
    bus.zahl1_i = z1;
    bus.zahl2_i = z2;
    bus.core_valid_i = 1'b0;
    step();
    check("ack", bus.ack_o, 64'(1 << exp_idx));
    check("erg_hold", bus.erg_o, last_erg);
    check("err_hold", bus.err_o, last_err);
    check("core_start", bus.core_start_o, !byp);
    if (!byp) check("core_zahl1", bus.core_zahl1_o, a);
    if (!hold) bus.req_i = '0;
    starts = 0;
    seen = 0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      step();
      starts += int'(bus.core_start_o);
      if (bus.done_o != '0) begin
        seen = 1;
        check("done_latency", k, exp_lat);
        check("done", bus.done_o, 64'(1 << exp_idx));
        check("erg", bus.erg_o, exp_erg);
        check("err", bus.err_o, exp_err);
        check("busy_after", bus.busy_o, 0);
      end else if (!byp && k == 1) begin
        check("core_zahl2_wait", bus.core_zahl2_o, b);
      end
      bus.core_valid_i = (k == lat);
      bus.core_erg_i = cerg;
    end
    if (!seen) check("done_timeout", 0, 1);
    check("extra_core_start", starts, 0);
    bus.core_valid_i = 1'b0;
    last_erg = exp_erg;
    last_err = exp_err;
    ref_ptr = (exp_idx + 1) % N;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, bus.ack_o, 0);
    check({tag, "_done"}, bus.done_o, 0);
    check({tag, "_erg"}, bus.erg_o, 0);
    check({tag, "_err"}, bus.err_o, 0);
    check({tag, "_busy"}, bus.busy_o, 0);
    check({tag, "_core_start"}, bus.core_start_o, 0);
    check({tag, "_core_zahl1"}, bus.core_zahl1_o, 0);
    check({tag, "_core_zahl2"}, bus.core_zahl2_o, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ref_ptr = 0;
    last_erg = '0;
    last_err = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*W-1:0] z1, z2;
    logic [N-1:0] m;
    logic [W-1:0] a, b, g, e;
    int idx, lat;
    bit byp;

    tbl[0] = '{4'b0100, 16'd48,  16'd18, 10, 16'd6,  2, 16'd6,  1'b0};
    tbl[1] = '{4'b0001, 16'd0,   16'd35,  0, 16'd0,  0, 16'd35, 1'b0};
    tbl[2] = '{4'b0010, 16'd100, 16'd75,  0, 16'd0,  1, 16'd0,  1'b1};
    tbl[3] = '{4'b1000, 16'd21,  16'd14,  3, 16'd7,  3, 16'd7,  1'b0};
    tbl[4] = '{4'b1010, 16'd9,   16'd6,  15, 16'd3,  1, 16'd3,  1'b0};
    tbl[5] = '{4'b1010, 16'd9,   16'd6,  16, 16'd3,  3, 16'd0,  1'b1};
    tbl[6] = '{4'b0001, 16'd0,   16'd0,   0, 16'd0,  0, 16'd0,  1'b0};
    tbl[7] = '{4'b1111, 16'd12,  16'd0,   0, 16'd0,  1, 16'd12, 1'b0};

    bus.req_i = '0;
    bus.zahl1_i = '0;
    bus.zahl2_i = '0;
    bus.core_valid_i = 1'b0;
    bus.core_erg_i = '0;
    rst_n = 1'b0;
    last_erg = '0;
    last_err = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Core valid while idle must not start anything.
    bus.core_valid_i = 1'b1;
    bus.core_erg_i = 16'd55;
    repeat (3) step();
    check("idle_valid_busy", bus.busy_o, 0);
    check("idle_valid_done", bus.done_o, 0);
    check("idle_valid_erg", bus.erg_o, 0);
    bus.core_valid_i = 1'b0;

    foreach (tbl[i]) begin
      do_txn(tbl[i].mask, {N{tbl[i].a}}, {N{tbl[i].b}}, tbl[i].lat, tbl[i].cerg, 1'b0,
             tbl[i].idx, tbl[i].erg, tbl[i].err);
    end

    // Held requests rotate strictly: 1111 -> 0,1,2,3 then 1001 -> 0,3,0,3.
    do_reset();
    for (int k = 0; k < N; k++) begin
      z1[k*W +: W] = '0;
      z2[k*W +: W] = W'(10 + k);
    end
    for (int k = 0; k < 4; k++)
      do_txn(4'b1111, z1, z2, 0, '0, 1'b1, k, W'(10 + k), 1'b0);
    for (int k = 0; k < 4; k++)
      do_txn(4'b1001, z1, z2, 0, '0, (k < 3), (k % 2 == 0) ? 0 : 3,
             (k % 2 == 0) ? W'(10) : W'(13), 1'b0);
    bus.req_i = '0;

    // Reset during WAIT abandons the transaction and rewinds the pointer.
    do_txn(4'b0010, z1, z2, 0, '0, 1'b0, 1, W'(11), 1'b0);
    bus.req_i = 4'b0100;
    bus.zahl1_i = {N{16'd30}};
    bus.zahl2_i = {N{16'd12}};
    step();
    check("rst_seq_ack", bus.ack_o, 4'b0100);
    bus.req_i = '0;
    repeat (3) step();
    check("rst_seq_busy", bus.busy_o, 1);
    do_reset();
    check_all_zero("mid_reset");
    do_txn(4'b1111, z1, z2, 0, '0, 1'b0, 0, W'(10), 1'b0);

    // Random traffic against the reference arbitration and GCD rules.
    for (int t = 0; t < 40; t++) begin
      m = N'($urandom_range(1, (1 << N) - 1));
      for (int k = 0; k < N; k++) begin
        int f;
        f = $urandom_range(1, 12);
        z1[k*W +: W] = ($urandom_range(0, 4) == 0) ? '0 : W'(f * $urandom_range(1, 5000));
        z2[k*W +: W] = ($urandom_range(0, 4) == 0) ? '0 : W'(f * $urandom_range(1, 5000));
      end
      lat = $urandom_range(1, 20);
      idx = ref_pick(m, ref_ptr);
      a = z1[idx*W +: W];
      b = z2[idx*W +: W];
      byp = (a == 0) || (b == 0);
      g = ref_gcd(a, b);
      e = byp ? (a | b) : ((lat <= TO) ? g : '0);
      do_txn(m, z1, z2, lat, g, 1'b0, idx, e, !byp && (lat > TO));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
